// File: rtl/merge_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | merge_arbiter: weighted round-robin packet merge of two streams into one    |
// | registered output stage.                                   Revision: 1.0    |
// +-----------------------------------------------------------------------------+
module merge_arbiter #(
  parameter int WIDTH    = 33,
  parameter int WEIGHT_A = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sel,
  output logic             o_last,
  output logic             busy
);

  localparam int               CNT_W      = (WEIGHT_A < 2) ? 1 : $clog2(WEIGHT_A + 1);
  localparam logic [CNT_W-1:0] WEIGHT_CNT = CNT_W'(WEIGHT_A);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_A = 2'd1;
  localparam logic [1:0] LOCK_B = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last_win;  // 1 = B won the most recent packet
  logic [CNT_W-1:0] a_cnt;
  logic             load_ok;
  logic             grant_a;
  logic             grant_b;
  logic             take_a;
  logic             take_b;
  logic             take;
  logic             take_last;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      LOCK_A: grant_a = 1'b1;
      LOCK_B: grant_b = 1'b1;
      default: begin
        if (a_valid && b_valid) begin
          if (last_win || (a_cnt < WEIGHT_CNT)) grant_a = 1'b1;
          else                                  grant_b = 1'b1;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
    endcase
  end

  assign load_ok   = !o_valid || o_ready;
  assign a_ready   = rst_n && grant_a && load_ok;
  assign b_ready   = rst_n && grant_b && load_ok;
  assign take_a    = a_valid && a_ready;
  assign take_b    = b_valid && b_ready;
  assign take      = take_a || take_b;
  assign take_last = take_a ? a_last : b_last;

  always_comb begin
    state_next = state;
    if (take) begin
      if (take_last)   state_next = IDLE;
      else if (take_a) state_next = LOCK_A;
      else             state_next = LOCK_B;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      last_win <= 1'b1;
      a_cnt    <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sel    <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (take) begin
        o_valid <= 1'b1;
        o_data  <= take_a ? a_data : b_data;
        o_sel   <= take_b;
        o_last  <= take_last;
        // Fairness bookkeeping advances only at packet boundaries.
        if (take_last) begin
          last_win <= take_b;
          if (take_b)                  a_cnt <= '0;
          else if (a_cnt < WEIGHT_CNT) a_cnt <= a_cnt + 1'b1;
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_merge_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_merge_arbiter: directed + random bench with a packet-level reference     |
// | model, covering WEIGHT_A=1 and WEIGHT_A=3.                 Revision: 1.0    |
// +-----------------------------------------------------------------------------+
module tb_merge_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        use3;
  logic        a_valid, b_valid, a_last, b_last, o_ready;
  logic [32:0] a_data, b_data;

  logic        rst_n1, rst_n3;
  logic        a_ready1, b_ready1, o_valid1, o_sel1, o_last1, busy1;
  logic        a_ready3, b_ready3, o_valid3, o_sel3, o_last3, busy3;
  logic [32:0] o_data1, o_data3;
  logic        a_ready_m, b_ready_m, o_valid_m, o_sel_m, o_last_m, busy_m;
  logic [32:0] o_data_m;

  always #5 clk = ~clk;

  assign rst_n1    = rst_n && !use3;
  assign rst_n3    = rst_n && use3;
  assign a_ready_m = use3 ? a_ready3 : a_ready1;
  assign b_ready_m = use3 ? b_ready3 : b_ready1;
  assign o_valid_m = use3 ? o_valid3 : o_valid1;
  assign o_data_m  = use3 ? o_data3  : o_data1;
  assign o_sel_m   = use3 ? o_sel3   : o_sel1;
  assign o_last_m  = use3 ? o_last3  : o_last1;
  assign busy_m    = use3 ? busy3    : busy1;

  merge_arbiter #(.WIDTH(33), .WEIGHT_A(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1),
    .a_valid(a_valid), .a_ready(a_ready1), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready1), .b_data(b_data), .b_last(b_last),
    .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1), .o_sel(o_sel1),
    .o_last(o_last1), .busy(busy1)
  );

  merge_arbiter #(.WIDTH(33), .WEIGHT_A(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3),
    .a_valid(a_valid), .a_ready(a_ready3), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready3), .b_data(b_data), .b_last(b_last),
    .o_valid(o_valid3), .o_ready(o_ready), .o_data(o_data3), .o_sel(o_sel3),
    .o_last(o_last3), .busy(busy3)
  );

  // Source packet queues ({last, data}) and consumed-beat log ({sel, data}).
  logic [33:0] aq[$];
  logic [33:0] bq[$];
  logic [33:0] log_q[$];

  int  total  = 0;
  int  passed = 0;
  bit  sat;
  bit  rnd_ready;
  bit  ready_cmd;
  bit  last_acc_b;

  // Reference model: owner of the current packet, who won last, A streak.
  int          m_owner;   // 0 none, 1 A, 2 B
  bit          m_lwb;
  int          m_streak;
  logic        m_ov;
  logic [32:0] m_od;
  logic        m_os;
  logic        m_ol;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_pkt(input bit to_b, input int len, input logic [32:0] base, input bit rnd);
    logic [32:0] d;
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        d[31:0] = $urandom();
        d[32]   = 1'($urandom_range(0, 1));
      end else begin
        d = base + 33'(i);
      end
      if (to_b) bq.push_back({(i == len - 1), d});
      else      aq.push_back({(i == len - 1), d});
    end
  endtask

  task automatic cycle();
    logic [33:0] ha, hb;
    bit ga, gb, room, ea, eb;
    int w;
    w = use3 ? 3 : 1;
    @(negedge clk);
    ha = (aq.size() > 0) ? aq[0] : '0;
    hb = (bq.size() > 0) ? bq[0] : '0;
    a_valid = (aq.size() > 0) && (sat || $urandom_range(0, 3) != 0);
    b_valid = (bq.size() > 0) && (sat || $urandom_range(0, 3) != 0);
    a_data  = ha[32:0];  a_last = ha[33];
    b_data  = hb[32:0];  b_last = hb[33];
    o_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (m_owner == 1)           ga = 1'b1;
    else if (m_owner == 2)      gb = 1'b1;
    else if (a_valid && b_valid) begin
      if (m_lwb || m_streak < w) ga = 1'b1;
      else                       gb = 1'b1;
    end else begin
      ga = a_valid; gb = b_valid;
    end
    room = !m_ov || o_ready;
    ea = rst_n && ga && a_valid && room;
    eb = rst_n && gb && b_valid && room;
    chk("accept_a", a_valid && a_ready_m, ea);
    chk("accept_b", b_valid && b_ready_m, eb);
    if (!rst_n || (m_ov && !o_ready)) begin
      chk("ready_a_zero", a_ready_m, 0);
      chk("ready_b_zero", b_ready_m, 0);
    end
    last_acc_b = b_valid && b_ready_m;
    if (rst_n && o_valid_m === 1'b1 && o_ready) log_q.push_back({o_sel_m, o_data_m});
    @(posedge clk);
    if (!rst_n) begin
      m_owner = 0; m_lwb = 1'b1; m_streak = 0;
      m_ov = 1'b0; m_od = '0; m_os = 1'b0; m_ol = 1'b0;
    end else if (ea || eb) begin
      m_ov = 1'b1;
      m_od = ea ? ha[32:0] : hb[32:0];
      m_os = eb;
      m_ol = ea ? ha[33] : hb[33];
      if (m_ol) begin
        m_owner = 0;
        m_lwb   = eb;
        if (eb)                 m_streak = 0;
        else if (m_streak < w)  m_streak++;
      end else begin
        m_owner = ea ? 1 : 2;
      end
      if (ea) void'(aq.pop_front());
      else    void'(bq.pop_front());
    end else if (o_ready) begin
      m_ov = 1'b0;
    end
    #1;
    chk("o_valid", o_valid_m, m_ov);
    if (m_ov) begin
      chk("o_data", o_data_m, m_od);
      chk("o_sel", o_sel_m, m_os);
      chk("o_last", o_last_m, m_ol);
    end
    chk("busy", busy_m, (m_owner != 0));
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((aq.size() > 0 || bq.size() > 0 || m_ov) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (n < bound), 1);
  endtask

  initial begin
    m_owner = 0; m_lwb = 1'b1; m_streak = 0;
    m_ov = 1'b0; m_od = '0; m_os = 1'b0; m_ol = 1'b0;
    a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; a_last = 0; b_last = 0;
    o_ready = 1; use3 = 0; sat = 1; rnd_ready = 0; ready_cmd = 1; last_acc_b = 0;
    rst_n = 0;
    @(posedge clk);

    // Reset with both sides requesting
    push_pkt(0, 1, 33'h1, 0);
    push_pkt(1, 1, 33'h2, 0);
    repeat (3) cycle();
    rst_n = 1;
    cycle();
    chk("first_data", o_data_m, 33'h1);
    chk("first_sel", o_sel_m, 0);
    drain(20);

    // Alternation with WEIGHT_A=1
    log_q.delete();
    for (int k = 0; k < 8; k++) begin
      push_pkt(0, 1, 33'h10 + 33'(k), 0);
      push_pkt(1, 1, 33'h20 + 33'(k), 0);
    end
    drain(40);
    chk("alt_len", log_q.size(), 16);
    for (int k = 0; k < 8; k++) begin
      chk("alt_a", log_q[2*k],   {1'b0, 33'h10 + 33'(k)});
      chk("alt_b", log_q[2*k+1], {1'b1, 33'h20 + 33'(k)});
    end

    // Packet lock
    log_q.delete();
    push_pkt(0, 3, 33'hA0, 0);
    push_pkt(1, 1, 33'hB0, 0);
    drain(20);
    chk("lock_len", log_q.size(), 4);
    chk("lock_0", log_q[0], {1'b0, 33'hA0});
    chk("lock_1", log_q[1], {1'b0, 33'hA1});
    chk("lock_2", log_q[2], {1'b0, 33'hA2});
    chk("lock_3", log_q[3], {1'b1, 33'hB0});

    // Backpressure mid-stream
    log_q.delete();
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 1, 33'h30 + 33'(k), 0);
      push_pkt(1, 1, 33'h40 + 33'(k), 0);
    end
    repeat (3) cycle();
    ready_cmd = 0;
    repeat (4) cycle();
    ready_cmd = 1;
    drain(40);
    chk("bp_len", log_q.size(), 8);
    for (int k = 0; k < 4; k++) begin
      chk("bp_a", log_q[2*k],   {1'b0, 33'h30 + 33'(k)});
      chk("bp_b", log_q[2*k+1], {1'b1, 33'h40 + 33'(k)});
    end

    // Random traffic, WEIGHT_A=1
    sat = 0; rnd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      push_pkt(0, $urandom_range(1, 3), '0, 1);
      push_pkt(1, $urandom_range(1, 3), '0, 1);
    end
    drain(2000);

    // Weight 3, saturated
    sat = 1; rnd_ready = 0; ready_cmd = 1;
    use3 = 1; rst_n = 0;
    repeat (2) cycle();
    rst_n = 1;
    log_q.delete();
    for (int k = 0; k < 12; k++) push_pkt(0, 1, 33'h50 + 33'(k), 0);
    for (int k = 0; k < 4; k++)  push_pkt(1, 1, 33'h60 + 33'(k), 0);
    drain(40);
    chk("w3_len", log_q.size(), 16);
    for (int k = 0; k < 16; k++) chk("w3_sel", log_q[k][33], ((k % 4) == 3));

    // Random traffic, WEIGHT_A=3
    sat = 0; rnd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      push_pkt(0, $urandom_range(1, 3), '0, 1);
      push_pkt(1, $urandom_range(1, 3), '0, 1);
    end
    drain(2000);

    // Reset in the middle of a locked A packet
    sat = 1; rnd_ready = 0; ready_cmd = 1;
    push_pkt(0, 3, 33'h70, 0);
    repeat (2) cycle();
    chk("mid_busy", busy_m, 1);
    aq.delete();
    rst_n = 0;
    cycle();
    chk("mid_rst_ovalid", o_valid_m, 0);
    chk("mid_rst_busy", busy_m, 0);
    rst_n = 1;
    push_pkt(1, 1, 33'h80, 0);
    cycle();
    chk("mid_b_grant", last_acc_b, 1);
    chk("mid_b_data", o_data_m, 33'h80);
    drain(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/merge_arbiter.md
# merge_arbiter

Clocked weighted round-robin arbiter-merge that shares one 33-bit output stream between two requesters, A and B. Requests are packets made of one or more beats, with `last` marking the final beat. A packet is never interleaved with the other side. Each output beat carries the select value that chose it, so downstream logic sees the same sel/data pairing a select-driven merge produces. The block sits in front of the shared output channel and is its sequencer.

## Interface
- `WIDTH`, default 33: data width per beat.
- `WEIGHT_A`, default 1: maximum consecutive A packets granted while B is waiting. Legal range is ≥1.
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `a_valid`  in  1: A presents a beat.
- `a_ready`  out  1: A beat accepted on this edge when `a_valid & a_ready`.
- `a_data`  in  WIDTH: A beat payload.
- `a_last`  in  1: A beat is the final beat of its packet.
- `b_valid`, `b_ready`, `b_data`, `b_last`: same as the A ports, for requester B.
- `o_valid`  out  1: output beat present.
- `o_ready`  in  1: downstream accepts the beat.
- `o_data`  out  WIDTH: output payload.
- `o_sel`  out  1: source of the beat. 0 = A, 1 = B.
- `o_last`  out  1: copy of the source `last` bit.
- `busy`  out  1: high while a multi-beat packet holds the lock (state ≠ IDLE).

## Operation
- **States:** IDLE, LOCK_A, LOCK_B.
- **Output register:** one stage holding o_valid, o_data, o_sel and o_last.
  - `load_ok = !o_valid | o_ready`.
  - A beat is accepted only when `load_ok`.
- **IDLE grant:**
  - If only one side is valid, grant that side.
  - If both are valid:
    - Grant A if `last_win == B`.
    - Grant A if `last_win == A` and `a_cnt < WEIGHT_A`.
    - Otherwise grant B.
- **Readies:** `a_ready = grant_a & load_ok`, `b_ready = grant_b & load_ok`.
  - In LOCK_A, only A is granted, regardless of `b_valid`. LOCK_B is the mirror.
  - Readies may depend combinationally on the valids. Valids must never depend on readies.
- **On an accepted beat with last=0 in IDLE:** go to LOCK_A or LOCK_B according to the winner.
- **On an accepted beat with last=1:** return to or stay in IDLE. Then:
  - Set `last_win` to the winning side.
  - If A won, `a_cnt` increments, saturating at WEIGHT_A.
  - If B won, `a_cnt` is cleared to 0.
- **Single-beat packets** never leave IDLE.
- **Locked, source idle:** while locked with the source not valid, the state holds, no beat is accepted, and the other side stays starved. The packet contract requires the source to finish its packet.
- **Register update:** on acceptance, o_data, o_sel and o_last load from the granted source and o_valid is set. Otherwise, if `o_valid & o_ready`, o_valid clears.
- **Reset:** in any cycle with rst_n=0:
  - a_ready = b_ready = 0.
  - The next edge sets o_valid=0, o_data=0, o_sel=0, o_last=0.
  - The next edge also sets state=IDLE, `last_win`=B (so A wins the first contest) and a_cnt=0.
- **Reset mid-packet:** the lock is dropped and any partial packet is discarded. A beat sitting in the output register is lost.

## Timing
- **Latency:** a beat accepted at edge N is on o_* from edge N until downstream takes it. This is one cycle of latency.
- **Throughput:** one beat per cycle with o_ready held high, including when packets switch from A to B back to back (no bubble).
- **Backpressure:** while `o_valid & !o_ready`:
  - both readies are 0;
  - o_data, o_sel and o_last are held stable;
  - state, `last_win` and a_cnt do not change.
- **Registered outputs:** o_valid, o_data, o_sel, o_last and busy all come from flops. There is no combinational path from o_ready to o_*.
- **Simultaneous events:** a downstream take and a new acceptance in the same cycle replace the register contents with no loss and no duplication.

## Test plan
1. **Reset:**
   - Stimulus: rst_n=0 for 3 cycles with a_valid=b_valid=1.
   - Required: a_ready=b_ready=0 and o_valid=0 throughout.
   - Required: after release, the first o_data is A's 0x1 with o_sel=0, one cycle after acceptance.
2. **Alternation, WEIGHT_A=1:**
   - Stimulus: both sides send single-beat packets (A: 0x10,0x11,…; B: 0x20,0x21,…) with o_ready=1.
   - Required: o_data is 0x10,0x20,0x11,0x21,… with o_sel toggling 0/1 every cycle.
3. **Packet lock:**
   - Stimulus: A sends the 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2) while b_valid=1 throughout.
   - Required: three contiguous o_sel=0 beats with busy=1 during beats 1–2, then B's beat.
4. **Backpressure:**
   - Stimulus: mid-stream, o_ready=0 for 4 cycles.
   - Required: o_data is held stable and the readies are 0.
   - Required: after release the sequence continues with no dropped or duplicated beats.
5. **Weight, WEIGHT_A=3:**
   - Stimulus: both sides saturated with single-beat packets.
   - Required: the o_sel pattern 0,0,0,1 repeats.
6. **Reset mid-packet:**
   - Stimulus: drop rst_n during beat 2 of a locked A packet, then release with only b_valid=1.
   - Required: o_valid=0 after the reset edge, busy=0, and B is granted on the first cycle after release.
